// File: rtl/audio_sample_scheduler.sv
// Audio ROM read-port scheduler: paces BGM/SFX fetches from codec data_over, mixes with saturation, sequences codec INIT.
// Optional: define SFX_DUCK_EN to attenuate BGM by 6 dB whenever the sample carries an SFX contribution.
//
// state      | meaning
// IDLE       | waiting for load_startpage
// INIT_CODEC | one-cycle INIT pulse to the codec, BGM pointer rewound
// WAIT_INIT  | waiting for INIT_FINISH from the codec
// PLAY       | pacing fetches and presenting mixed samples
module audio_sample_scheduler #(
    parameter int ADDR_W    = 19,
    parameter int DATA_W    = 16,
    parameter int BGM_START = 0,
    parameter int BGM_END   = 85114,
    parameter int DIV       = 10
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              load_startpage,
    input  logic              game_over,
    input  logic              INIT_FINISH,
    input  logic              data_over,
    input  logic              sfx_trig,
    input  logic [ADDR_W-1:0] sfx_start,
    input  logic [ADDR_W-1:0] sfx_len,
    input  logic [DATA_W-1:0] rom_data,
    output logic              INIT,
    output logic [ADDR_W-1:0] rom_addr,
    output logic [DATA_W-1:0] sample_out,
    output logic              sample_valid,
    output logic              sfx_busy,
    output logic              bgm_active
);

    localparam int DIV_W = 10;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_INIT_CODEC,
        ST_WAIT_INIT,
        ST_PLAY
    } state_t;

    typedef enum logic [2:0] {
        SEQ_IDLE,
        SEQ_ADDR_SFX,
        SEQ_CAP_BGM,
        SEQ_CAP_SFX,
        SEQ_MIX
    } seq_t;

    state_t            state_q, state_d;
    seq_t              seq_q, seq_d;
    logic              init_q, init_d;
    logic              bgm_active_q, bgm_active_d;
    logic [DIV_W-1:0]  div_cnt_q, div_cnt_d;
    logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
    logic [ADDR_W-1:0] bgm_ptr_q, bgm_ptr_d;
    logic [ADDR_W-1:0] sfx_ptr_q, sfx_ptr_d;
    logic [ADDR_W-1:0] sfx_rem_q, sfx_rem_d;
    logic              sfx_busy_q, sfx_busy_d;
    logic              slot_used_q, slot_used_d;
    logic [DATA_W-1:0] bgm_smp_q, bgm_smp_d;
    logic [DATA_W-1:0] sfx_smp_q, sfx_smp_d;
    logic [DATA_W-1:0] sample_out_q, sample_out_d;
    logic              sample_valid_q, sample_valid_d;

    logic              tick;
    logic              leave_play;
    logic [DATA_W-1:0] bgm_mix;
    logic [DATA_W:0]   mix_sum;
    logic [DATA_W-1:0] mix_sat;

    // Ducking follows the sample's own SFX slot: sfx_busy may already have
    // dropped by the time the final SFX sample reaches the mixer.
    always_comb begin
`ifdef SFX_DUCK_EN
        bgm_mix = slot_used_q ? {bgm_smp_q[DATA_W-1], bgm_smp_q[DATA_W-1:1]} : bgm_smp_q;
`else
        bgm_mix = bgm_smp_q;
`endif
        mix_sum = {bgm_mix[DATA_W-1], bgm_mix} + {sfx_smp_q[DATA_W-1], sfx_smp_q};
        if (mix_sum[DATA_W] != mix_sum[DATA_W-1]) begin
            mix_sat = mix_sum[DATA_W] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
        end else begin
            mix_sat = mix_sum[DATA_W-1:0];
        end
    end

    always_comb begin
        state_d        = state_q;
        seq_d          = seq_q;
        init_d         = 1'b0;
        bgm_active_d   = bgm_active_q;
        div_cnt_d      = div_cnt_q;
        rom_addr_d     = rom_addr_q;
        bgm_ptr_d      = bgm_ptr_q;
        sfx_ptr_d      = sfx_ptr_q;
        sfx_rem_d      = sfx_rem_q;
        sfx_busy_d     = sfx_busy_q;
        slot_used_d    = slot_used_q;
        bgm_smp_d      = bgm_smp_q;
        sfx_smp_d      = sfx_smp_q;
        sample_out_d   = sample_out_q;
        sample_valid_d = 1'b0;
        tick           = 1'b0;
        leave_play     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (load_startpage) begin
                    state_d = ST_INIT_CODEC;
                    init_d  = 1'b1;
                end
            end
            ST_INIT_CODEC: begin
                state_d   = ST_WAIT_INIT;
                bgm_ptr_d = ADDR_W'(BGM_START);
            end
            ST_WAIT_INIT: begin
                if (INIT_FINISH) begin
                    state_d      = ST_PLAY;
                    bgm_active_d = 1'b1;
                end
            end
            ST_PLAY: begin
                if (game_over) begin
                    state_d      = ST_IDLE;
                    bgm_active_d = 1'b0;
                    leave_play   = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (state_q == ST_PLAY && data_over) begin
            if (div_cnt_q == DIV_W'(DIV - 1)) begin
                div_cnt_d = '0;
                tick      = 1'b1;
            end else begin
                div_cnt_d = div_cnt_q + DIV_W'(1);
            end
        end

        // Ticks that land while a fetch is in flight are dropped.
        case (seq_q)
            SEQ_IDLE: begin
                if (tick) begin
                    rom_addr_d = bgm_ptr_q;
                    seq_d      = SEQ_ADDR_SFX;
                end
            end
            SEQ_ADDR_SFX: begin
                rom_addr_d  = sfx_busy_q ? sfx_ptr_q : bgm_ptr_q;
                slot_used_d = sfx_busy_q;
                bgm_ptr_d   = (bgm_ptr_q == ADDR_W'(BGM_END)) ? ADDR_W'(BGM_START)
                                                             : bgm_ptr_q + ADDR_W'(1);
                if (sfx_busy_q) begin
                    sfx_ptr_d = sfx_ptr_q + ADDR_W'(1);
                    sfx_rem_d = sfx_rem_q - ADDR_W'(1);
                end
                seq_d = SEQ_CAP_BGM;
            end
            SEQ_CAP_BGM: begin
                bgm_smp_d = rom_data;
                seq_d     = SEQ_CAP_SFX;
            end
            SEQ_CAP_SFX: begin
                sfx_smp_d = slot_used_q ? rom_data : '0;
                seq_d     = SEQ_MIX;
            end
            SEQ_MIX: begin
                sample_out_d   = mix_sat;
                sample_valid_d = 1'b1;
                seq_d          = SEQ_IDLE;
            end
            default: seq_d = SEQ_IDLE;
        endcase

        if (sfx_busy_q && sfx_rem_q == '0) begin
            sfx_busy_d = 1'b0;
        end

        // A trigger on the slot cycle overrides the advance; the slot itself already used the old pointer.
        if (sfx_trig && sfx_len != '0 && state_q != ST_IDLE) begin
            sfx_ptr_d  = sfx_start;
            sfx_rem_d  = sfx_len;
            sfx_busy_d = 1'b1;
        end

        if (leave_play) begin
            seq_d          = SEQ_IDLE;
            div_cnt_d      = '0;
            sample_out_d   = '0;
            sample_valid_d = 1'b0;
            sfx_busy_d     = 1'b0;
            sfx_rem_d      = '0;
            slot_used_d    = 1'b0;
            bgm_smp_d      = '0;
            sfx_smp_d      = '0;
        end
    end

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state_q        <= ST_IDLE;
            seq_q          <= SEQ_IDLE;
            init_q         <= 1'b0;
            bgm_active_q   <= 1'b0;
            div_cnt_q      <= '0;
            rom_addr_q     <= '0;
            bgm_ptr_q      <= ADDR_W'(BGM_START);
            sfx_ptr_q      <= '0;
            sfx_rem_q      <= '0;
            sfx_busy_q     <= 1'b0;
            slot_used_q    <= 1'b0;
            bgm_smp_q      <= '0;
            sfx_smp_q      <= '0;
            sample_out_q   <= '0;
            sample_valid_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            seq_q          <= seq_d;
            init_q         <= init_d;
            bgm_active_q   <= bgm_active_d;
            div_cnt_q      <= div_cnt_d;
            rom_addr_q     <= rom_addr_d;
            bgm_ptr_q      <= bgm_ptr_d;
            sfx_ptr_q      <= sfx_ptr_d;
            sfx_rem_q      <= sfx_rem_d;
            sfx_busy_q     <= sfx_busy_d;
            slot_used_q    <= slot_used_d;
            bgm_smp_q      <= bgm_smp_d;
            sfx_smp_q      <= sfx_smp_d;
            sample_out_q   <= sample_out_d;
            sample_valid_q <= sample_valid_d;
        end
    end

    assign INIT         = init_q;
    assign rom_addr     = rom_addr_q;
    assign sample_out   = sample_out_q;
    assign sample_valid = sample_valid_q;
    assign sfx_busy     = sfx_busy_q;
    assign bgm_active   = bgm_active_q;

endmodule

// File: tb/tb_audio_sample_scheduler.sv
// Bench for audio_sample_scheduler: directed scenarios plus a randomized run against a transaction-level model.
module tb_audio_sample_scheduler;
    localparam int ADDR_W    = 19;
    localparam int DATA_W    = 16;
    localparam int BGM_START = 0;
    localparam int BGM_END   = 3;
    localparam int DIV       = 10;
`ifdef SFX_DUCK_EN
    localparam int DUCK_SH   = 1;
`else
    localparam int DUCK_SH   = 0;
`endif

    logic              Clk = 1'b0;
    logic              Reset, load_startpage, game_over, INIT_FINISH, data_over, sfx_trig;
    logic [ADDR_W-1:0] sfx_start, sfx_len;
    logic [DATA_W-1:0] rom_data;
    logic              INIT, sample_valid, sfx_busy, bgm_active;
    logic [ADDR_W-1:0] rom_addr;
    logic [DATA_W-1:0] sample_out;
    logic [DATA_W-1:0] mem [0:511];
    int total = 0;
    int bad   = 0;
    int m_bgm;

    audio_sample_scheduler #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .BGM_START(BGM_START), .BGM_END(BGM_END), .DIV(DIV)
    ) dut (
        .Clk(Clk), .Reset(Reset), .load_startpage(load_startpage), .game_over(game_over),
        .INIT_FINISH(INIT_FINISH), .data_over(data_over), .sfx_trig(sfx_trig),
        .sfx_start(sfx_start), .sfx_len(sfx_len), .rom_data(rom_data), .INIT(INIT),
        .rom_addr(rom_addr), .sample_out(sample_out), .sample_valid(sample_valid),
        .sfx_busy(sfx_busy), .bgm_active(bgm_active)
    );

    always #5 Clk = ~Clk;
    always @(posedge Clk) rom_data <= mem[rom_addr[8:0]];

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached, summary not reached");
        $fatal(1);
    end

    function automatic int next_bgm(input int p);
        return (p == BGM_END) ? BGM_START : p + 1;
    endfunction

    function automatic logic [15:0] mix_ref(input logic [15:0] b, input logic [15:0] s, input bit used);
        int bi, si, sum;
        bi = int'($signed(b));
        si = int'($signed(s));
        if (used) bi = bi >>> DUCK_SH;
        sum = bi + si;
        if (sum > 32767) sum = 32767;
        if (sum < -32768) sum = -32768;
        return sum[15:0];
    endfunction

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    // Ten data_over pulses; returns one cycle after the tenth (first cycle of the fetch).
    task automatic fire(input int gap, output int n_valid);
        n_valid = 0;
        for (int i = 0; i < DIV; i++) begin
            data_over = 1'b1;
            step();
            data_over = 1'b0;
            if (sample_valid) n_valid++;
            if (i < DIV - 1) begin
                for (int g = 0; g < gap; g++) begin
                    step();
                    if (sample_valid) n_valid++;
                end
            end
        end
    endtask

    task automatic trig(input int start, input int len);
        sfx_trig  = 1'b1;
        sfx_start = ADDR_W'(start);
        sfx_len   = ADDR_W'(len);
        step();
        sfx_trig  = 1'b0;
    endtask

    task automatic start_play();
        load_startpage = 1'b1;
        step();
        load_startpage = 1'b0;
        step();
        INIT_FINISH = 1'b1;
        step();
        INIT_FINISH = 1'b0;
        m_bgm = BGM_START;
    endtask

    task automatic test_reset();
        Reset = 1'b0;
        load_startpage = 1'b1;
        repeat (3) step();
        total++;
        if ({INIT, rom_addr, sample_out, sample_valid, sfx_busy, bgm_active} !== '0) begin
            bad++;
            $display("FAIL reset_outputs: got INIT=%b addr=%h out=%h valid=%b busy=%b active=%b, want all 0",
                     INIT, rom_addr, sample_out, sample_valid, sfx_busy, bgm_active);
        end
        load_startpage = 1'b0;
        Reset = 1'b1;
        step();
        total++;
        if (INIT !== 1'b0 || bgm_active !== 1'b0) begin
            bad++;
            $display("FAIL reset_idle: got INIT=%b active=%b, want 0 0", INIT, bgm_active);
        end
    endtask

    task automatic test_startup();
        bit ok;
        game_over = 1'b1;
        step();
        game_over = 1'b0;
        load_startpage = 1'b1;
        step();
        load_startpage = 1'b0;
        total++;
        if (INIT !== 1'b1) begin bad++; $display("FAIL init_pulse: got %b want 1", INIT); end
        step();
        total++;
        if (INIT !== 1'b0) begin bad++; $display("FAIL init_width: got %b want 0", INIT); end
        game_over = 1'b1;
        step();
        game_over = 1'b0;
        ok = 1'b1;
        repeat (4) begin
            step();
            if (bgm_active !== 1'b0 || INIT !== 1'b0) ok = 1'b0;
        end
        total++;
        if (!ok) begin bad++; $display("FAIL wait_init_hold: got active/INIT high, want 0 before INIT_FINISH"); end
        INIT_FINISH = 1'b1;
        step();
        INIT_FINISH = 1'b0;
        total++;
        if (bgm_active !== 1'b1) begin bad++; $display("FAIL play_entry: got %b want 1", bgm_active); end
        m_bgm = BGM_START;
    endtask

    task automatic test_pacing();
        int nv, vcount;
        logic [DATA_W-1:0] exp_s;
        vcount = 0;
        for (int k = 0; k < 3; k++) begin
            fire(7, nv);
            vcount += nv;
            total++;
            if (rom_addr !== ADDR_W'(m_bgm)) begin
                bad++; $display("FAIL pace_addr: got %h want %h", rom_addr, m_bgm);
            end
            exp_s = mem[m_bgm];
            for (int p = 2; p <= 8; p++) begin
                step();
                if (sample_valid) vcount++;
                if (p == 5) begin
                    total++;
                    if (sample_valid !== 1'b1 || sample_out !== exp_s) begin
                        bad++; $display("FAIL pace_sample: got v=%b %h want v=1 %h", sample_valid, sample_out, exp_s);
                    end
                end
            end
            m_bgm = next_bgm(m_bgm);
        end
        total++;
        if (vcount !== 3) begin bad++; $display("FAIL pace_count: got %0d want 3", vcount); end
    endtask

    task automatic test_wrap();
        int nv;
        for (int k = 0; k < 3; k++) begin
            fire(0, nv);
            total++;
            if (rom_addr !== ADDR_W'(m_bgm)) begin
                bad++; $display("FAIL wrap_addr: got %h want %h", rom_addr, m_bgm);
            end
            repeat (4) step();
            total++;
            if (sample_valid !== 1'b1 || sample_out !== mem[m_bgm]) begin
                bad++; $display("FAIL wrap_sample: got v=%b %h want v=1 %h", sample_valid, sample_out, mem[m_bgm]);
            end
            m_bgm = next_bgm(m_bgm);
        end
    endtask

    task automatic test_sfx_mix();
        int nv;
        logic [DATA_W-1:0] exp_hi, exp_duck;
        exp_hi   = (DUCK_SH != 0) ? 16'h5800 : 16'h7FFF;
        exp_duck = (DUCK_SH != 0) ? 16'h2000 : 16'h4000;
        mem[m_bgm]  = 16'h7000;
        mem[9'h180] = 16'h2000;
        mem[9'h181] = 16'hA000;
        mem[9'h190] = 16'h0000;
        trig(32'h180, 2);
        total++;
        if (sfx_busy !== 1'b1) begin bad++; $display("FAIL sfx_accept: got %b want 1", sfx_busy); end
        fire(0, nv);
        step();
        total++;
        if (rom_addr !== 19'h180) begin bad++; $display("FAIL sfx_addr0: got %h want 180", rom_addr); end
        repeat (3) step();
        total++;
        if (sample_valid !== 1'b1 || sample_out !== exp_hi) begin
            bad++; $display("FAIL sat_pos: got v=%b %h want v=1 %h", sample_valid, sample_out, exp_hi);
        end
        total++;
        if (sfx_busy !== 1'b1) begin bad++; $display("FAIL sfx_busy_mid: got %b want 1", sfx_busy); end
        m_bgm = next_bgm(m_bgm);
        mem[m_bgm] = 16'h9000;
        fire(0, nv);
        step();
        total++;
        if (rom_addr !== 19'h181) begin bad++; $display("FAIL sfx_addr1: got %h want 181", rom_addr); end
        repeat (3) step();
        total++;
        if (sample_valid !== 1'b1 || sample_out !== 16'h8000) begin
            bad++; $display("FAIL sat_neg: got v=%b %h want v=1 8000", sample_valid, sample_out);
        end
        total++;
        if (sfx_busy !== 1'b0) begin bad++; $display("FAIL sfx_done: got %b want 0", sfx_busy); end
        m_bgm = next_bgm(m_bgm);
        mem[m_bgm] = 16'h4000;
        trig(32'h190, 1);
        fire(0, nv);
        repeat (4) step();
        total++;
        if (sample_out !== exp_duck) begin bad++; $display("FAIL duck: got %h want %h", sample_out, exp_duck); end
        m_bgm = next_bgm(m_bgm);
        fire(0, nv);
        step();
        total++;
        if (rom_addr !== ADDR_W'(m_bgm)) begin
            bad++; $display("FAIL sfx_idle_hold: got %h want %h", rom_addr, m_bgm);
        end
        repeat (3) step();
        m_bgm = next_bgm(m_bgm);
    endtask

    task automatic test_retrigger();
        int nv;
        logic [DATA_W-1:0] exp_s;
        trig(32'h120, 5);
        fire(1, nv);
        sfx_trig  = 1'b1;
        sfx_start = 19'h100;
        sfx_len   = 19'd3;
        step();
        sfx_trig  = 1'b0;
        total++;
        if (rom_addr !== 19'h120) begin bad++; $display("FAIL trig_on_slot_addr: got %h want 120", rom_addr); end
        exp_s = mix_ref(mem[m_bgm], mem[9'h120], 1'b1);
        repeat (3) step();
        total++;
        if (sample_out !== exp_s) begin bad++; $display("FAIL trig_on_slot_mix: got %h want %h", sample_out, exp_s); end
        m_bgm = next_bgm(m_bgm);
        fire(1, nv);
        step();
        total++;
        if (rom_addr !== 19'h100) begin bad++; $display("FAIL retrig_addr: got %h want 100", rom_addr); end
        repeat (3) step();
        m_bgm = next_bgm(m_bgm);
        trig(32'h140, 3);
        fire(0, nv);
        step();
        total++;
        if (rom_addr !== 19'h140) begin bad++; $display("FAIL retrig_mid: got %h want 140", rom_addr); end
        repeat (3) step();
        m_bgm = next_bgm(m_bgm);
        trig(32'h1F0, 0);
        fire(0, nv);
        step();
        total++;
        if (rom_addr !== 19'h141) begin bad++; $display("FAIL len0_ignored: got %h want 141", rom_addr); end
        repeat (3) step();
        m_bgm = next_bgm(m_bgm);
    endtask

    task automatic test_abort();
        int nv, vc;
        trig(32'h150, 8);
        fire(0, nv);
        step();
        step();
        game_over = 1'b1;
        data_over = 1'b1;
        step();
        game_over = 1'b0;
        data_over = 1'b0;
        total++;
        if (bgm_active !== 1'b0 || sample_out !== '0 || sfx_busy !== 1'b0) begin
            bad++; $display("FAIL abort_clear: got active=%b out=%h busy=%b want 0 0 0", bgm_active, sample_out, sfx_busy);
        end
        vc = 0;
        repeat (4) begin step(); if (sample_valid) vc++; end
        total++;
        if (vc !== 0) begin bad++; $display("FAIL abort_no_valid: got %0d pulses want 0", vc); end
        fire(0, nv);
        repeat (6) begin step(); if (sample_valid) nv++; end
        total++;
        if (nv !== 0) begin bad++; $display("FAIL idle_no_fetch: got %0d pulses want 0", nv); end
        start_play();
        fire(0, nv);
        total++;
        if (rom_addr !== ADDR_W'(BGM_START)) begin
            bad++; $display("FAIL restart_addr: got %h want %h", rom_addr, BGM_START);
        end
        repeat (3) step();
        total++;
        if (sample_valid !== 1'b0) begin bad++; $display("FAIL restart_early: got v=%b want 0", sample_valid); end
        step();
        total++;
        if (sample_valid !== 1'b1 || sample_out !== mem[BGM_START]) begin
            bad++; $display("FAIL restart_sample: got v=%b %h want v=1 %h", sample_valid, sample_out, mem[BGM_START]);
        end
        m_bgm = next_bgm(m_bgm);
    endtask

    task automatic test_reset_midfetch();
        int nv;
        trig(32'h160, 4);
        fire(0, nv);
        step();
        Reset = 1'b0;
        step();
        total++;
        if ({INIT, rom_addr, sample_out, sample_valid, sfx_busy, bgm_active} !== '0) begin
            bad++;
            $display("FAIL reset_midfetch: got INIT=%b addr=%h out=%h valid=%b busy=%b active=%b, want all 0",
                     INIT, rom_addr, sample_out, sample_valid, sfx_busy, bgm_active);
        end
        Reset = 1'b1;
        step();
        start_play();
    endtask

    task automatic test_random();
        int nv, rem, sptr, st, ln, slot_addr;
        bit used;
        logic [DATA_W-1:0] exp_s, s_val;
        for (int i = 0; i < 4; i++) mem[i] = 16'($urandom);
        for (int i = 256; i < 512; i++) mem[i] = 16'($urandom);
        rem  = 0;
        sptr = 0;
        for (int n = 0; n < 24; n++) begin
            if ($urandom_range(0, 1) == 1) begin
                st = 256 + $urandom_range(0, 200);
                ln = $urandom_range(0, 3);
                trig(st, ln);
                if (ln != 0) begin
                    sptr = st;
                    rem  = ln;
                end
            end
            used = (rem > 0);
            if (used) begin
                s_val     = mem[sptr];
                slot_addr = sptr;
                sptr++;
                rem--;
            end else begin
                s_val     = '0;
                slot_addr = m_bgm;
            end
            exp_s = mix_ref(mem[m_bgm], s_val, used);
            fire($urandom_range(0, 2), nv);
            total++;
            if (nv !== 0 || rom_addr !== ADDR_W'(m_bgm)) begin
                bad++; $display("FAIL rand_addr_bgm: got %h (early v=%0d) want %h", rom_addr, nv, m_bgm);
            end
            step();
            total++;
            if (rom_addr !== ADDR_W'(slot_addr)) begin
                bad++; $display("FAIL rand_addr_slot: got %h want %h", rom_addr, slot_addr);
            end
            repeat (3) step();
            total++;
            if (sample_valid !== 1'b1 || sample_out !== exp_s) begin
                bad++; $display("FAIL rand_sample: got v=%b %h want v=1 %h", sample_valid, sample_out, exp_s);
            end
            total++;
            if (sfx_busy !== (rem > 0)) begin
                bad++; $display("FAIL rand_busy: got %b want %b", sfx_busy, (rem > 0));
            end
            m_bgm = next_bgm(m_bgm);
            repeat ($urandom_range(0, 3)) step();
        end
    endtask

    initial begin
        Reset = 1'b0;
        load_startpage = 1'b0;
        game_over = 1'b0;
        INIT_FINISH = 1'b0;
        data_over = 1'b0;
        sfx_trig = 1'b0;
        sfx_start = '0;
        sfx_len = '0;
        m_bgm = BGM_START;
        for (int i = 0; i < 512; i++) mem[i] = 16'(i + 256);
        test_reset();
        test_startup();
        test_pacing();
        test_wrap();
        test_sfx_mix();
        test_retrigger();
        test_abort();
        test_reset_midfetch();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
